branch_resolve_unit: RTL and testbench

//  Parametrised successor of the exe-stage prediction checker. Holds the predictions of in-flight instructions in an
//  in-order queue (fetch pushes, exe pops), checks each prediction at resolve time, and produces a registered

---
 rtl/branch_resolve_unit_pkg.sv | 42 ++++
 rtl/branch_resolve_unit_if.sv | 40 ++++
 rtl/branch_resolve_unit_pred_queue.sv | 81 ++++++++
 rtl/branch_resolve_unit.sv | 179 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : drac_pkg                                                      |
// | Description: Shared types for the branch resolve unit. Holds the PC type,  |
// |              instruction type, branch decision, fetch-stage prediction    |
// |              record and a helper that classifies conditional branches.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package drac_pkg;

   typedef logic [39:0] addrPC_t;

   typedef enum logic [3:0] {
      INSTR_OTHER = 4'd0,
      JAL         = 4'd1,
      JALR        = 4'd2,
      BEQ         = 4'd3,
      BNE         = 4'd4,
      BLT         = 4'd5,
      BGE         = 4'd6,
      BLTU        = 4'd7,
      BGEU        = 4'd8
   } instr_type_t;

   typedef enum logic {
      NOT_TAKEN = 1'b0,
      TAKEN     = 1'b1
   } branch_decision_t;

   typedef struct packed {
      logic             is_branch;
      branch_decision_t decision;
      addrPC_t          pred_addr;
   } branch_pred_t;

   function automatic logic is_cond_branch(input instr_type_t t);
      return (t == BEQ) || (t == BNE) || (t == BLT) ||
             (t == BGE) || (t == BLTU) || (t == BGEU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : branch_resolve_unit_if                                        |
// | Description: Fetch push channel and exe resolve channel of the branch      |
// |              resolve unit.                                                 |
// |   push_valid/push_pc/push_pred : one prediction per accepted push          |
// |   push_ready                   : queue can accept (driven by the unit)     |
// |   resolve_valid/type/taken/next_pc : exe outcome for the oldest entry      |
// |   stall                        : exe stalled, resolve ignored              |
// |   master = fetch/exe side, slave = branch resolve unit                     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface branch_resolve_unit_if;
   import drac_pkg::*;

   logic             push_valid;
   addrPC_t          push_pc;
   branch_pred_t     push_pred;
   logic             push_ready;

   logic             resolve_valid;
   instr_type_t      resolve_type;
   branch_decision_t resolve_taken;
   addrPC_t          resolve_next_pc;
   logic             stall;

   modport master (
      output push_valid, push_pc, push_pred,
      input  push_ready,
      output resolve_valid, resolve_type, resolve_taken, resolve_next_pc, stall
   );

   modport slave (
      input  push_valid, push_pc, push_pred,
      output push_ready,
      input  resolve_valid, resolve_type, resolve_taken, resolve_next_pc, stall
   );

endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_pred_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : bru_pred_queue                                                |
// | Description: DEPTH-entry in-order circular FIFO of {pc, prediction}.       |
// |   clk_i, rstn_i        : clock, synchronous active-low reset               |
// |   push_i, push_pc_i, push_pred_i : write one entry (caller ensures !full)  |
// |   pop_i                : retire head entry (caller ensures !empty)         |
// |   flush_i              : empty the queue, overrides push and pop           |
// |   head_pc_o/head_pred_o: oldest entry                                      |
// |   full_o, empty_o, occupancy_o : fill status from registered pointers      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bru_pred_queue
   import drac_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     push_i,
   input  addrPC_t                  push_pc_i,
   input  branch_pred_t             push_pred_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output addrPC_t                  head_pc_o,
   output branch_pred_t             head_pred_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra MSB so equal indices can be told apart as
   // full (MSBs differ) or empty (MSBs equal).
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   addrPC_t      pc_mem_q   [DEPTH];
   branch_pred_t pred_mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read while the pointers say
   // they hold valid data.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         pc_mem_q[wr_ptr_q[AW-1:0]]   <= push_pc_i;
         pred_mem_q[wr_ptr_q[AW-1:0]] <= push_pred_i;
      end
   end

   assign head_pc_o   = pc_mem_q[rd_ptr_q[AW-1:0]];
   assign head_pred_o = pred_mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o     = (wr_ptr_q == rd_ptr_q);
   assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign occupancy_o = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : branch_resolve_unit                                           |
// | Description: Queues fetch-stage predictions of in-flight instructions,     |
// |              checks the oldest one when exe resolves it and raises a       |
// |              registered redirect on mispredict. Emits predictor update     |
// |              beats and keeps saturating branch/mispredict counters.        |
// |   clk_i, rstn_i    : clock, synchronous active-low reset                   |
// |   bus (slave)      : push channel from fetch, resolve channel from exe     |
// |   flush_i          : external flush, empties the queue                     |
// |   correct_o        : result of last resolve (1 = correct)                  |
// |   redirect_valid_o/redirect_pc_o : one-cycle refetch request              |
// |   upd_valid_o/upd_pc_o/upd_taken_o/upd_target_o : predictor update beat   |
// |   occupancy_o      : entries held                                          |
// |   cnt_branch_o/cnt_mispred_o : saturating performance counters            |
// |   resolve_err_o    : sticky, resolve seen with an empty queue              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module branch_resolve_unit
   import drac_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_WIDTH = 32,
   parameter bit          BP_EN     = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   branch_resolve_unit_if.slave     bus,
   input  logic                     flush_i,
   output logic                     correct_o,
   output logic                     redirect_valid_o,
   output addrPC_t                  redirect_pc_o,
   output logic                     upd_valid_o,
   output addrPC_t                  upd_pc_o,
   output branch_decision_t         upd_taken_o,
   output addrPC_t                  upd_target_o,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic [CNT_WIDTH-1:0]     cnt_branch_o,
   output logic [CNT_WIDTH-1:0]     cnt_mispred_o,
   output logic                     resolve_err_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   addrPC_t      head_pc;
   branch_pred_t head_pred;
   logic         q_full;
   logic         q_empty;
   logic         q_flush;
   logic         push_en;
   logic         pop_en;
   logic         check_ok;
   logic         mispred;
   logic         is_ctrl;
   logic         is_counted;

   logic                   correct_q,        correct_d;
   logic                   redirect_valid_q, redirect_valid_d;
   addrPC_t                redirect_pc_q,    redirect_pc_d;
   logic                   upd_valid_q,      upd_valid_d;
   addrPC_t                upd_pc_q,         upd_pc_d;
   branch_decision_t       upd_taken_q,      upd_taken_d;
   addrPC_t                upd_target_q,     upd_target_d;
   logic [CNT_WIDTH-1:0]   cnt_branch_q,     cnt_branch_d;
   logic [CNT_WIDTH-1:0]   cnt_mispred_q,    cnt_mispred_d;
   logic                   resolve_err_q,    resolve_err_d;

   // A conditional branch/JALR is correct only if a taken prediction named
   // the real next PC, or a not-taken prediction matched a not-taken outcome.
   // With prediction disabled fetch is static not-taken, so any such
   // instruction is treated as mispredicted.
   function automatic logic pred_ok(input instr_type_t      t,
                                    input branch_pred_t     p,
                                    input branch_decision_t act_dec,
                                    input addrPC_t          next_pc);
      logic ok;
      if (t == JAL) begin
         ok = 1'b1;
      end else if (is_cond_branch(t) || (t == JALR)) begin
         if (BP_EN)
            ok = ((p.decision == TAKEN) && (p.pred_addr == next_pc)) ||
                 ((p.decision == NOT_TAKEN) && (act_dec == NOT_TAKEN));
         else
            ok = 1'b0;
      end else begin
         ok = !p.is_branch || (p.decision == NOT_TAKEN);
      end
      return ok;
   endfunction

   always_comb begin
      pop_en     = bus.resolve_valid && !bus.stall && !q_empty && !flush_i;
      check_ok   = pred_ok(bus.resolve_type, head_pred, bus.resolve_taken,
                           bus.resolve_next_pc);
      mispred    = pop_en && !check_ok;
      // Ready is the registered !full, so a pop this cycle never frees a slot
      // for a same-cycle push; a mispredict discards the wrong-path push.
      push_en    = bus.push_valid && !q_full && !flush_i && !mispred;
      q_flush    = flush_i || mispred;
      is_ctrl    = (bus.resolve_type == JAL) || (bus.resolve_type == JALR) ||
                   is_cond_branch(bus.resolve_type);
      is_counted = (bus.resolve_type == JALR) || is_cond_branch(bus.resolve_type);
   end

   bru_pred_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .push_i      (push_en),
      .push_pc_i   (bus.push_pc),
      .push_pred_i (bus.push_pred),
      .pop_i       (pop_en),
      .flush_i     (q_flush),
      .head_pc_o   (head_pc),
      .head_pred_o (head_pred),
      .full_o      (q_full),
      .empty_o     (q_empty),
      .occupancy_o (occupancy_o)
   );

   always_comb begin
      correct_d        = pop_en ? check_ok : correct_q;
      redirect_valid_d = mispred;
      redirect_pc_d    = mispred ? bus.resolve_next_pc : redirect_pc_q;
      upd_valid_d      = pop_en && is_ctrl;
      upd_pc_d         = upd_valid_d ? head_pc : upd_pc_q;
      upd_taken_d      = upd_valid_d ? bus.resolve_taken : upd_taken_q;
      upd_target_d     = upd_valid_d ? bus.resolve_next_pc : upd_target_q;
      cnt_branch_d     = cnt_branch_q;
      if (pop_en && is_counted && (cnt_branch_q != '1))
         cnt_branch_d = cnt_branch_q + CNT_ONE;
      cnt_mispred_d    = cnt_mispred_q;
      if (mispred && (cnt_mispred_q != '1))
         cnt_mispred_d = cnt_mispred_q + CNT_ONE;
      resolve_err_d    = resolve_err_q ||
                         (bus.resolve_valid && !bus.stall && q_empty);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         correct_q        <= 1'b1;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         upd_valid_q      <= 1'b0;
         upd_pc_q         <= '0;
         upd_taken_q      <= NOT_TAKEN;
         upd_target_q     <= '0;
         cnt_branch_q     <= '0;
         cnt_mispred_q    <= '0;
         resolve_err_q    <= 1'b0;
      end else begin
         correct_q        <= correct_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         upd_valid_q      <= upd_valid_d;
         upd_pc_q         <= upd_pc_d;
         upd_taken_q      <= upd_taken_d;
         upd_target_q     <= upd_target_d;
         cnt_branch_q     <= cnt_branch_d;
         cnt_mispred_q    <= cnt_mispred_d;
         resolve_err_q    <= resolve_err_d;
      end
   end

   assign bus.push_ready   = !q_full;
   assign correct_o        = correct_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign upd_valid_o      = upd_valid_q;
   assign upd_pc_o         = upd_pc_q;
   assign upd_taken_o      = upd_taken_q;
   assign upd_target_o     = upd_target_q;
   assign cnt_branch_o     = cnt_branch_q;
   assign cnt_mispred_o    = cnt_mispred_q;
   assign resolve_err_o    = resolve_err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_branch_resolve_unit                                        |
// | Description: Directed self-checking bench. Unit A predicts (BP_EN=1,       |
// |              32-bit counters); unit B is static not-taken (BP_EN=0) with   |
// |              2-bit counters so saturation is reachable quickly.            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_branch_resolve_unit;
   import drac_pkg::*;

   logic clk;
   logic rstn;
   logic a_flush, b_flush;
   int   checks;
   int   errors;

   logic             a_correct, a_redir, a_upd, a_err;
   addrPC_t          a_redir_pc, a_upd_pc, a_upd_tgt;
   branch_decision_t a_upd_taken;
   logic [2:0]       a_occ;
   logic [31:0]      a_cntb, a_cntm;

   logic             b_correct, b_redir, b_upd, b_err;
   addrPC_t          b_redir_pc, b_upd_pc, b_upd_tgt;
   branch_decision_t b_upd_taken;
   logic [2:0]       b_occ;
   logic [1:0]       b_cntb, b_cntm;

   branch_resolve_unit_if ifa ();
   branch_resolve_unit_if ifb ();

   branch_resolve_unit #(.DEPTH(4), .CNT_WIDTH(32), .BP_EN(1'b1)) dut_a (
      .clk_i(clk), .rstn_i(rstn), .bus(ifa), .flush_i(a_flush),
      .correct_o(a_correct), .redirect_valid_o(a_redir), .redirect_pc_o(a_redir_pc),
      .upd_valid_o(a_upd), .upd_pc_o(a_upd_pc), .upd_taken_o(a_upd_taken),
      .upd_target_o(a_upd_tgt), .occupancy_o(a_occ), .cnt_branch_o(a_cntb),
      .cnt_mispred_o(a_cntm), .resolve_err_o(a_err)
   );

   branch_resolve_unit #(.DEPTH(4), .CNT_WIDTH(2), .BP_EN(1'b0)) dut_b (
      .clk_i(clk), .rstn_i(rstn), .bus(ifb), .flush_i(b_flush),
      .correct_o(b_correct), .redirect_valid_o(b_redir), .redirect_pc_o(b_redir_pc),
      .upd_valid_o(b_upd), .upd_pc_o(b_upd_pc), .upd_taken_o(b_upd_taken),
      .upd_target_o(b_upd_tgt), .occupancy_o(b_occ), .cnt_branch_o(b_cntb),
      .cnt_mispred_o(b_cntm), .resolve_err_o(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ifa.push_valid = 1'b0; ifa.push_pc = '0; ifa.push_pred = '0;
      ifa.resolve_valid = 1'b0; ifa.resolve_type = INSTR_OTHER;
      ifa.resolve_taken = NOT_TAKEN; ifa.resolve_next_pc = '0; ifa.stall = 1'b0;
      ifb.push_valid = 1'b0; ifb.push_pc = '0; ifb.push_pred = '0;
      ifb.resolve_valid = 1'b0; ifb.resolve_type = INSTR_OTHER;
      ifb.resolve_taken = NOT_TAKEN; ifb.resolve_next_pc = '0; ifb.stall = 1'b0;
      a_flush = 1'b0; b_flush = 1'b0;
   endtask

   task automatic drive_push_a(input addrPC_t pc, input logic br,
                               input branch_decision_t dec, input addrPC_t addr);
      ifa.push_valid = 1'b1; ifa.push_pc = pc;
      ifa.push_pred.is_branch = br; ifa.push_pred.decision = dec;
      ifa.push_pred.pred_addr = addr;
   endtask

   task automatic drive_resolve_a(input instr_type_t t, input branch_decision_t tk,
                                  input addrPC_t npc);
      ifa.resolve_valid = 1'b1; ifa.resolve_type = t;
      ifa.resolve_taken = tk; ifa.resolve_next_pc = npc;
   endtask

   task automatic test_reset();
      idle_all();
      rstn = 1'b0;
      tick(); tick();
      checks++; if (ifa.push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ifa.push_ready); end
      checks++; if (a_correct !== 1'b1) begin errors++; $display("FAIL reset_correct got %b want 1", a_correct); end
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", a_occ); end
      checks++; if ({a_redir, a_upd, a_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {a_redir, a_upd, a_err}); end
      checks++; if ({a_cntb, a_cntm} !== 64'd0) begin errors++; $display("FAIL reset_counters got %h want 0", {a_cntb, a_cntm}); end
      checks++; if (b_correct !== 1'b1) begin errors++; $display("FAIL reset_b_correct got %b want 1", b_correct); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_non_branch();
      for (int i = 0; i < 3; i++) begin
         drive_push_a(40'h10 + 40'(4*i), 1'b0, NOT_TAKEN, 40'h0);
         tick();
      end
      idle_all();
      checks++; if (a_occ !== 3'd3) begin errors++; $display("FAIL nb_fill_occ got %0d want 3", a_occ); end
      for (int i = 0; i < 3; i++) begin
         drive_resolve_a(INSTR_OTHER, NOT_TAKEN, 40'h14 + 40'(4*i));
         tick();
         checks++; if (a_correct !== 1'b1) begin errors++; $display("FAIL nb_correct[%0d] got %b want 1", i, a_correct); end
         checks++; if ({a_redir, a_upd} !== 2'b00) begin errors++; $display("FAIL nb_pulses[%0d] got %b want 00", i, {a_redir, a_upd}); end
         checks++; if (a_occ !== 3'(2-i)) begin errors++; $display("FAIL nb_occ[%0d] got %0d want %0d", i, a_occ, 2-i); end
      end
      idle_all();
      tick();
   endtask

   task automatic test_branch_taken();
      drive_push_a(40'h40, 1'b1, TAKEN, 40'h100);
      tick();
      idle_all();
      drive_resolve_a(BEQ, TAKEN, 40'h100);
      tick();
      idle_all();
      checks++; if (a_correct !== 1'b1) begin errors++; $display("FAIL bt_correct got %b want 1", a_correct); end
      checks++; if (a_upd !== 1'b1) begin errors++; $display("FAIL bt_upd_valid got %b want 1", a_upd); end
      checks++; if (a_upd_pc !== 40'h40) begin errors++; $display("FAIL bt_upd_pc got %h want 40", a_upd_pc); end
      checks++; if (a_upd_taken !== TAKEN) begin errors++; $display("FAIL bt_upd_taken got %b want 1", a_upd_taken); end
      checks++; if (a_upd_tgt !== 40'h100) begin errors++; $display("FAIL bt_upd_target got %h want 100", a_upd_tgt); end
      checks++; if (a_redir !== 1'b0) begin errors++; $display("FAIL bt_redirect got %b want 0", a_redir); end
      checks++; if (a_cntb !== 32'd1) begin errors++; $display("FAIL bt_cnt_branch got %0d want 1", a_cntb); end
      tick();
      checks++; if (a_upd !== 1'b0) begin errors++; $display("FAIL bt_upd_one_cycle got %b want 0", a_upd); end
   endtask

   task automatic test_mispredict();
      drive_push_a(40'h200, 1'b1, NOT_TAKEN, 40'h0); tick();
      drive_push_a(40'h204, 1'b0, NOT_TAKEN, 40'h0); tick();
      drive_push_a(40'h208, 1'b0, NOT_TAKEN, 40'h0); tick();
      idle_all();
      checks++; if (a_occ !== 3'd3) begin errors++; $display("FAIL mp_fill_occ got %0d want 3", a_occ); end
      drive_resolve_a(BNE, TAKEN, 40'h2000);
      drive_push_a(40'h20c, 1'b0, NOT_TAKEN, 40'h0);
      tick();
      idle_all();
      checks++; if (a_redir !== 1'b1) begin errors++; $display("FAIL mp_redirect got %b want 1", a_redir); end
      checks++; if (a_redir_pc !== 40'h2000) begin errors++; $display("FAIL mp_redirect_pc got %h want 2000", a_redir_pc); end
      checks++; if (a_correct !== 1'b0) begin errors++; $display("FAIL mp_correct got %b want 0", a_correct); end
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL mp_occ got %0d want 0", a_occ); end
      checks++; if (a_cntm !== 32'd1) begin errors++; $display("FAIL mp_cnt_mispred got %0d want 1", a_cntm); end
      checks++; if (a_cntb !== 32'd2) begin errors++; $display("FAIL mp_cnt_branch got %0d want 2", a_cntb); end
      tick();
      checks++; if (a_redir !== 1'b0) begin errors++; $display("FAIL mp_redirect_one_cycle got %b want 0", a_redir); end
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL mp_push_dropped occ got %0d want 0", a_occ); end
   endtask

   task automatic test_full_stall();
      for (int i = 0; i < 4; i++) begin
         drive_push_a(40'h300 + 40'(4*i), 1'b1, TAKEN, 40'h400);
         tick();
      end
      checks++; if (ifa.push_ready !== 1'b0) begin errors++; $display("FAIL fs_ready_full got %b want 0", ifa.push_ready); end
      checks++; if (a_occ !== 3'd4) begin errors++; $display("FAIL fs_occ_full got %0d want 4", a_occ); end
      drive_push_a(40'h310, 1'b1, TAKEN, 40'h400);
      tick();
      idle_all();
      checks++; if (a_occ !== 3'd4) begin errors++; $display("FAIL fs_fifth_dropped occ got %0d want 4", a_occ); end
      drive_resolve_a(JAL, TAKEN, 40'h400);
      ifa.stall = 1'b1;
      tick();
      checks++; if (a_occ !== 3'd4) begin errors++; $display("FAIL fs_stall_occ got %0d want 4", a_occ); end
      checks++; if ({a_redir, a_upd} !== 2'b00) begin errors++; $display("FAIL fs_stall_pulses got %b want 00", {a_redir, a_upd}); end
      checks++; if (a_correct !== 1'b0) begin errors++; $display("FAIL fs_stall_correct_hold got %b want 0", a_correct); end
      ifa.stall = 1'b0;
      drive_push_a(40'h314, 1'b1, TAKEN, 40'h400);
      tick();
      ifa.push_valid = 1'b0;
      checks++; if (a_occ !== 3'd3) begin errors++; $display("FAIL fs_pushpop_full occ got %0d want 3", a_occ); end
      checks++; if (a_upd_pc !== 40'h300) begin errors++; $display("FAIL fs_head0 upd_pc got %h want 300", a_upd_pc); end
      checks++; if (a_correct !== 1'b1) begin errors++; $display("FAIL fs_jal_correct got %b want 1", a_correct); end
      for (int i = 1; i < 4; i++) begin
         tick();
         checks++; if (a_upd_pc !== 40'h300 + 40'(4*i)) begin errors++; $display("FAIL fs_order[%0d] upd_pc got %h want %h", i, a_upd_pc, 40'h300 + 40'(4*i)); end
      end
      idle_all();
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL fs_drain_occ got %0d want 0", a_occ); end
      checks++; if (a_cntb !== 32'd2) begin errors++; $display("FAIL fs_jal_not_counted got %0d want 2", a_cntb); end
      tick();
   endtask

   task automatic test_empty_err();
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL ee_err_before got %b want 0", a_err); end
      drive_resolve_a(BEQ, TAKEN, 40'h999);
      tick();
      idle_all();
      checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL ee_err_set got %b want 1", a_err); end
      checks++; if ({a_redir, a_upd} !== 2'b00) begin errors++; $display("FAIL ee_pulses got %b want 00", {a_redir, a_upd}); end
      tick(); tick();
      checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL ee_err_sticky got %b want 1", a_err); end
   endtask

   task automatic test_flush();
      drive_push_a(40'h500, 1'b1, NOT_TAKEN, 40'h0); tick();
      drive_push_a(40'h504, 1'b0, NOT_TAKEN, 40'h0); tick();
      idle_all();
      checks++; if (a_occ !== 3'd2) begin errors++; $display("FAIL fl_occ_before got %0d want 2", a_occ); end
      a_flush = 1'b1;
      drive_resolve_a(BNE, TAKEN, 40'h3000);
      tick();
      idle_all();
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL fl_occ got %0d want 0", a_occ); end
      checks++; if ({a_redir, a_upd} !== 2'b00) begin errors++; $display("FAIL fl_pulses got %b want 00", {a_redir, a_upd}); end
      checks++; if (a_cntm !== 32'd1) begin errors++; $display("FAIL fl_cnt_mispred got %0d want 1", a_cntm); end
      tick();
   endtask

   task automatic test_bp_disabled();
      ifb.push_valid = 1'b1; ifb.push_pc = 40'h600;
      ifb.push_pred.is_branch = 1'b1; ifb.push_pred.decision = NOT_TAKEN; ifb.push_pred.pred_addr = 40'h0;
      tick();
      ifb.push_valid = 1'b0;
      ifb.resolve_valid = 1'b1; ifb.resolve_type = BGE; ifb.resolve_taken = NOT_TAKEN; ifb.resolve_next_pc = 40'h604;
      tick();
      idle_all();
      checks++; if (b_redir !== 1'b1) begin errors++; $display("FAIL bd_bge_redirect got %b want 1", b_redir); end
      checks++; if (b_redir_pc !== 40'h604) begin errors++; $display("FAIL bd_bge_pc got %h want 604", b_redir_pc); end
      checks++; if (b_correct !== 1'b0) begin errors++; $display("FAIL bd_bge_correct got %b want 0", b_correct); end
      checks++; if (b_cntm !== 2'd1) begin errors++; $display("FAIL bd_cnt_mispred got %0d want 1", b_cntm); end
      ifb.push_valid = 1'b1; ifb.push_pc = 40'h700;
      ifb.push_pred.is_branch = 1'b1; ifb.push_pred.decision = TAKEN; ifb.push_pred.pred_addr = 40'h800;
      tick();
      ifb.push_valid = 1'b0;
      ifb.resolve_valid = 1'b1; ifb.resolve_type = JAL; ifb.resolve_taken = TAKEN; ifb.resolve_next_pc = 40'h800;
      tick();
      idle_all();
      checks++; if ({b_correct, b_redir, b_upd} !== 3'b101) begin errors++; $display("FAIL bd_jal got %b want 101", {b_correct, b_redir, b_upd}); end
      for (int i = 0; i < 3; i++) begin
         ifb.push_valid = 1'b1; ifb.push_pc = 40'h900 + 40'(8*i);
         ifb.push_pred.is_branch = 1'b1; ifb.push_pred.decision = TAKEN; ifb.push_pred.pred_addr = 40'hA00;
         tick();
         ifb.push_valid = 1'b0;
         ifb.resolve_valid = 1'b1; ifb.resolve_type = BGE; ifb.resolve_taken = TAKEN; ifb.resolve_next_pc = 40'hA00;
         tick();
         idle_all();
         checks++; if (b_redir !== 1'b1) begin errors++; $display("FAIL bd_static_redirect[%0d] got %b want 1", i, b_redir); end
         checks++; if (b_cntm !== ((i < 1) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL bd_sat_mispred[%0d] got %0d want %0d", i, b_cntm, (i < 1) ? 2 : 3); end
      end
      checks++; if (b_cntb !== 2'd3) begin errors++; $display("FAIL bd_sat_branch got %0d want 3", b_cntb); end
      tick();
   endtask

   task automatic test_mid_reset();
      drive_push_a(40'hB00, 1'b0, NOT_TAKEN, 40'h0); tick();
      drive_push_a(40'hB04, 1'b0, NOT_TAKEN, 40'h0); tick();
      checks++; if (a_occ !== 3'd2) begin errors++; $display("FAIL mr_occ_before got %0d want 2", a_occ); end
      drive_resolve_a(BEQ, TAKEN, 40'hC00);
      rstn = 1'b0;
      tick();
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL mr_occ got %0d want 0", a_occ); end
      checks++; if ({a_err, a_redir, a_upd, a_correct} !== 4'b0001) begin errors++; $display("FAIL mr_flags got %b want 0001", {a_err, a_redir, a_upd, a_correct}); end
      checks++; if ({a_cntb, a_cntm, b_cntm} !== 66'd0) begin errors++; $display("FAIL mr_counters got %h want 0", {a_cntb, a_cntm, b_cntm}); end
      idle_all();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      idle_all();
      test_reset();
      test_non_branch();
      test_branch_taken();
      test_mispredict();
      test_full_stall();
      test_empty_err();
      test_flush();
      test_bp_disabled();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
